// File: rtl/bus_protocol_pkg.sv
// Shared types and constants for the round-robin bus protocol arbiter.
// Build option: define BUS_ARB_TIMEOUT_RETRY_EN so that a timed-out requester
// gets one immediate retry before the round-robin pointer moves on.
package bus_protocol_pkg;

  // Default bus data width
  localparam int DW = 8;

  // Earliest dValid beat in which dAck is accepted
  localparam int MIN_VALID = 2;

  // Last dValid beat before the transfer is forced to end
  localparam int MAX_VALID = 4;

  // Width of the beat counter; must hold MAX_VALID
  localparam int CNT_W = 3;

  // Arbiter FSM states
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request bit at or after ptr,
// wrapping modulo N_REQ. Produces both a one-hot winner and its index.
module rr_arbiter
  import bus_protocol_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic [PW-1:0]    win_idx
);

  logic          found;
  logic [PW-1:0] cand;

  // Walk the requests once, starting at ptr, and keep the first hit
  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        winner[cand]  = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/bus_protocol_arbiter.sv
// Round-robin bus master: shares one dValid/dAck/data bus among N_REQ
// requesters. Each transfer holds dValid for 2..MAX_VALID clocks with data
// frozen, ends on an accepted dAck or on timeout, and reports the outcome
// with one-cycle ack/tmo pulses to the owning requester.
// Build option: BUS_ARB_TIMEOUT_RETRY_EN keeps the pointer on a requester
// after its first consecutive timeout so it is re-granted first.
module bus_protocol_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = bus_protocol_pkg::DW,
  parameter int MIN_VALID = bus_protocol_pkg::MIN_VALID,
  parameter int MAX_VALID = bus_protocol_pkg::MAX_VALID
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    tmo,
  output logic                early_err,
  output logic                dValid,
  output logic [DW-1:0]       data,
  input  logic                dAck
);

  import bus_protocol_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    ptr_after;
  logic [N_REQ-1:0] win_onehot;
  logic [PW-1:0]    win_idx;
  logic             accept;
  logic             timeout;
  logic             early;

`ifdef BUS_ARB_TIMEOUT_RETRY_EN
  logic             retried;
  logic [PW-1:0]    retry_idx;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr),
    .winner  (win_onehot),
    .win_idx (win_idx)
  );

  // Pointer position just past the current owner, wrapping at N_REQ
  assign ptr_after = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);

  // Transfer exits and the early-acknowledge flag, evaluated in XFER only
  assign accept  = dAck && (cnt >= CNT_W'(MIN_VALID));
  assign timeout = !accept && (cnt == CNT_W'(MAX_VALID));
  assign early   = dAck && (cnt < CNT_W'(MIN_VALID));

  // Main FSM: grant in IDLE, sequence dValid in XFER, all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      grant_idx <= '0;
      grant     <= '0;
      data      <= '0;
      dValid    <= 1'b0;
      ack       <= '0;
      tmo       <= '0;
      early_err <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_RETRY_EN
      retried   <= 1'b0;
      retry_idx <= '0;
`endif
    end else begin
      ack       <= '0;
      tmo       <= '0;
      early_err <= 1'b0;
      case (state)
        IDLE: begin
          dValid <= 1'b0;
          cnt    <= '0;
          if (|req) begin
            grant     <= win_onehot;
            grant_idx <= win_idx;
            data      <= req_data[int'(win_idx) * DW +: DW];
            dValid    <= 1'b1;
            cnt       <= CNT_W'(1);
            state     <= XFER;
          end
        end

        XFER: begin
          cnt <= cnt + CNT_W'(1);
          if (early) begin
            early_err <= 1'b1;
          end
          if (accept) begin
            dValid  <= 1'b0;
            ack     <= grant;
            grant   <= '0;
            cnt     <= '0;
            state   <= IDLE;
            ptr     <= ptr_after;
`ifdef BUS_ARB_TIMEOUT_RETRY_EN
            retried <= 1'b0;
`endif
          end else if (timeout) begin
            dValid <= 1'b0;
            tmo    <= grant;
            grant  <= '0;
            cnt    <= '0;
            state  <= IDLE;
`ifdef BUS_ARB_TIMEOUT_RETRY_EN
            if (retried && (retry_idx == grant_idx)) begin
              ptr     <= ptr_after;
              retried <= 1'b0;
            end else begin
              ptr       <= grant_idx;
              retried   <= 1'b1;
              retry_idx <= grant_idx;
            end
`else
            ptr <= ptr_after;
`endif
          end
        end

        default: begin
          state  <= IDLE;
          dValid <= 1'b0;
          grant  <= '0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_protocol_arbiter.sv
// Testbench for bus_protocol_arbiter: table of transfers, each pushed to a
// scoreboard queue when driven and popped when the bus transfer completes,
// plus a hand-written asynchronous reset in the middle of a transfer.
module tb_bus_protocol_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int NVEC  = 11;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*DW-1:0] req_data = '0;
  logic                dAck = 1'b0;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    ack;
  logic [N_REQ-1:0]    tmo;
  logic                early_err;
  logic                dValid;
  logic [DW-1:0]       data;

  typedef struct {
    bit          do_reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [4:0]  dack_mask;
    int          exp_idx;
    logic [7:0]  exp_data;
    int          exp_len;
    logic [3:0]  exp_ack;
    logic [3:0]  exp_tmo;
    int          exp_early;
  } vec_t;

  vec_t vecs[NVEC];
  vec_t sb_q[$];
  int   compared = 0;
  int   mismatched = 0;

  bus_protocol_arbiter #(
    .N_REQ     (N_REQ),
    .DW        (DW),
    .MIN_VALID (2),
    .MAX_VALID (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .ack       (ack),
    .tmo       (tmo),
    .early_err (early_err),
    .dValid    (dValid),
    .data      (data),
    .dAck      (dAck)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reset_seq();
    @(negedge clk);
    reset_n = 1'b0;
    dAck    = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive one transfer from the table and compare it against the scoreboard
  task automatic apply_stimulus(input vec_t v);
    int         waited;
    int         len;
    int         early;
    bit         unstable;
    logic [3:0] g0;
    logic [7:0] d0;
    vec_t       e;
    if (v.do_reset) reset_seq();
    req      = v.req;
    req_data = v.req_data;
    dAck     = 1'b0;
    sb_q.push_back(v);
    waited = 0;
    while (dValid !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_output("latency", waited, 1);
    if (dValid !== 1'b1) begin
      void'(sb_q.pop_front());
      return;
    end
    g0 = grant;
    d0 = data;
    len = 0;
    early = 0;
    unstable = 1'b0;
    while (dValid === 1'b1 && len < 8) begin
      len++;
      if (grant !== g0 || data !== d0) unstable = 1'b1;
      if (early_err === 1'b1) early++;
      dAck = (len <= 4) ? v.dack_mask[len[2:0]] : 1'b0;
      @(negedge clk);
    end
    dAck = 1'b0;
    if (early_err === 1'b1) early++;
    e = sb_q.pop_front();
    check_output("grant", 32'(g0), 32'(4'b0001 << e.exp_idx));
    check_output("data", 32'(d0), 32'(e.exp_data));
    check_output("valid_len", len, e.exp_len);
    check_output("stable", 32'(unstable), 32'd0);
    check_output("early_err", early, e.exp_early);
    check_output("ack", 32'(ack), 32'(e.exp_ack));
    check_output("tmo", 32'(tmo), 32'(e.exp_tmo));
    check_output("grant_release", 32'(grant), 32'd0);
  endtask

  initial begin
    vec_t post;
    int   waited;

    // Transfer table: reset, req, req_data, dAck beats, expected outcome
    vecs[0]  = '{1'b1, 4'b0001, 32'hD4C3B2A5, 5'b00100, 0, 8'hA5, 2, 4'b0001, 4'b0000, 0};
    vecs[1]  = '{1'b1, 4'b1111, 32'hD4C3B2A5, 5'b01000, 0, 8'hA5, 3, 4'b0001, 4'b0000, 0};
    vecs[2]  = '{1'b0, 4'b1111, 32'hD4C3B2A5, 5'b01000, 1, 8'hB2, 3, 4'b0010, 4'b0000, 0};
    vecs[3]  = '{1'b0, 4'b1111, 32'hD4C3B2A5, 5'b01000, 2, 8'hC3, 3, 4'b0100, 4'b0000, 0};
    vecs[4]  = '{1'b0, 4'b1111, 32'hD4C3B2A5, 5'b01000, 3, 8'hD4, 3, 4'b1000, 4'b0000, 0};
    vecs[5]  = '{1'b0, 4'b1111, 32'hD4C3B2A5, 5'b01000, 0, 8'hA5, 3, 4'b0001, 4'b0000, 0};
    vecs[6]  = '{1'b0, 4'b0010, 32'hD4C3B2A5, 5'b01010, 1, 8'hB2, 3, 4'b0010, 4'b0000, 1};
    vecs[7]  = '{1'b0, 4'b1100, 32'hD4C3B2A5, 5'b00000, 2, 8'hC3, 4, 4'b0000, 4'b0100, 0};
`ifdef BUS_ARB_TIMEOUT_RETRY_EN
    vecs[8]  = '{1'b0, 4'b1100, 32'hD4C3B2A5, 5'b10000, 2, 8'hC3, 4, 4'b0100, 4'b0000, 0};
`else
    vecs[8]  = '{1'b0, 4'b1100, 32'hD4C3B2A5, 5'b10000, 3, 8'hD4, 4, 4'b1000, 4'b0000, 0};
`endif
    vecs[9]  = '{1'b0, 4'b0101, 32'h1122335A, 5'b00100, 0, 8'h5A, 2, 4'b0001, 4'b0000, 0};
    vecs[10] = '{1'b0, 4'b0010, 32'h1122335A, 5'b00110, 1, 8'h33, 2, 4'b0010, 4'b0000, 1};

    // Reset state
    reset_n = 1'b0;
    @(negedge clk);
    check_output("rst_dValid", 32'(dValid), 32'd0);
    check_output("rst_data", 32'(data), 32'd0);
    check_output("rst_grant", 32'(grant), 32'd0);
    check_output("rst_ack", 32'(ack), 32'd0);
    check_output("rst_tmo", 32'(tmo), 32'd0);
    check_output("rst_early_err", 32'(early_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
    end

    // Reset in the middle of a transfer owned by requester 2 (pointer is 2)
    req      = 4'b1100;
    req_data = 32'hD4C3B2A5;
    dAck     = 1'b0;
    waited   = 0;
    while (dValid !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_output("mid_rst_grant_before", 32'(grant), 32'b0100);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_dValid", 32'(dValid), 32'd0);
    check_output("mid_rst_grant", 32'(grant), 32'd0);
    check_output("mid_rst_data", 32'(data), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_output("mid_rst_ack", 32'(ack), 32'd0);
      check_output("mid_rst_tmo", 32'(tmo), 32'd0);
    end
    reset_n = 1'b1;

    // First grant after release goes to requester 0 even though 2 requests
    post = '{1'b0, 4'b1101, 32'hD4C3B2A5, 5'b00100, 0, 8'hA5, 2, 4'b0001, 4'b0000, 0};
    apply_stimulus(post);
    req = '0;

    check_output("scoreboard_empty", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
